// File: rtl/gmm_fg_detector_pipe_p.sv
// rtl/gmm_fg_detector_pipe_p.sv - GMM foreground detector: pipelined sqrt, std clamp, fg flag and counter
module gmm_fg_detector_pipe_p #(
   parameter int K       = 3,
   parameter int CH      = 3,
   parameter int VAR_W   = 16,
   parameter int STD_W   = 8,
   parameter int W_W     = 8,
   parameter int SIDE_W  = 32,
   parameter int CNT_W   = 32,
   localparam int IDX_W  = $clog2(K + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    snk_valid,
   output logic                    snk_ready,
   input  logic [K*VAR_W-1:0]      snk_var,
   input  logic [K*W_W-1:0]        snk_w,
   input  logic [K*CH*8-1:0]       snk_mean,
   input  logic [IDX_W-1:0]        snk_clusters_num,
   input  logic [IDX_W-1:0]        snk_p_max_idx,
   input  logic [IDX_W-1:0]        snk_B,
   input  logic [SIDE_W-1:0]       snk_side,
   input  logic [STD_W-1:0]        std_min,
   input  logic [STD_W-1:0]        std_max,
   input  logic                    clr_cnt,
   input  logic                    src_ready,
   output logic                    src_valid,
   output logic [K*STD_W-1:0]      src_std,
   output logic [K*W_W-1:0]        src_w,
   output logic [K*CH*8-1:0]       src_mean,
   output logic [IDX_W-1:0]        src_clusters_num,
   output logic                    src_is_fg,
   output logic [SIDE_W-1:0]       src_side,
   output logic [CNT_W-1:0]        fg_cnt
);

   // H sqrt stages, one result bit each; RW holds the signed partial remainder
   localparam int H    = VAR_W / 2;
   localparam int RW   = H + 2;
   localparam int MW   = CH * 8;
   localparam int O_W  = 0;
   localparam int O_M  = O_W + K * W_W;
   localparam int O_CN = O_M + K * MW;
   localparam int O_FG = O_CN + IDX_W;
   localparam int O_SD = O_FG + 1;
   localparam int PW   = O_SD + SIDE_W;

   // One non-restoring step: shift in two radicand bits, add or subtract by remainder sign
   function automatic logic [RW+H-1:0] nr_step(input logic [RW-1:0] r,
                                                input logic [H-1:0]  q,
                                                input logic [1:0]    d);
      logic [RW-1:0] rs;
      logic [RW-1:0] rn;
      rs = {r[RW-3:0], d};
      if (r[RW-1]) rn = rs + {q, 2'b11};
      else         rn = rs - {q, 2'b01};
      return {rn, q[H-2:0], ~rn[RW-1]};
   endfunction

   function automatic logic [STD_W-1:0] clamp_std(input logic [H-1:0]     q,
                                                  input logic [STD_W-1:0] lo,
                                                  input logic [STD_W-1:0] hi);
      logic [STD_W-1:0] s;
      s = STD_W'(q);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return s;
   endfunction

   logic               en;
   logic [K*W_W-1:0]   in_w;
   logic [K*MW-1:0]    in_mean;
   logic               in_fg;
   logic [PW-1:0]      in_pay;

   logic [K*VAR_W-1:0] st_var [H];
   logic [K*RW-1:0]    st_r   [H];
   logic [K*H-1:0]     st_q   [H];
   logic [PW-1:0]      st_pay [H];
   logic               st_vld [H];

   logic [K*VAR_W-1:0] pv_var [H];
   logic [K*RW-1:0]    pv_r   [H];
   logic [K*H-1:0]     pv_q   [H];
   logic [PW-1:0]      pv_pay [H];
   logic               pv_vld [H];
   logic [K*RW-1:0]    nx_r   [H];
   logic [K*H-1:0]     nx_q   [H];

   logic [IDX_W-1:0]   out_cn;
   logic [K*STD_W-1:0] out_std;
   logic               fire;
   logic               unused_tail;

   assign en        = ~src_valid | src_ready;
   assign snk_ready = en;

   // Zero weights and means of inactive clusters on entry so they travel already masked
   always_comb begin
      in_w    = snk_w;
      in_mean = snk_mean;
      for (int k = 0; k < K; k++) begin
         if (IDX_W'(k) >= snk_clusters_num) begin
            in_w[k*W_W +: W_W] = '0;
            in_mean[k*MW +: MW] = '0;
         end
      end
   end

   assign in_fg  = snk_p_max_idx > snk_B;
   assign in_pay = {snk_side, in_fg, snk_clusters_num, in_mean, in_w};

   generate
      for (genvar i = 0; i < H; i++) begin : g_stage
         if (i == 0) begin : g_first
            assign pv_var[i] = snk_var;
            assign pv_r[i]   = '0;
            assign pv_q[i]   = '0;
            assign pv_pay[i] = in_pay;
            assign pv_vld[i] = snk_valid;
         end else begin : g_next
            assign pv_var[i] = st_var[i-1];
            assign pv_r[i]   = st_r[i-1];
            assign pv_q[i]   = st_q[i-1];
            assign pv_pay[i] = st_pay[i-1];
            assign pv_vld[i] = st_vld[i-1];
         end
         for (genvar k = 0; k < K; k++) begin : g_clu
            assign {nx_r[i][k*RW +: RW], nx_q[i][k*H +: H]} =
               nr_step(pv_r[i][k*RW +: RW], pv_q[i][k*H +: H],
                       pv_var[i][k*VAR_W + 2*(H-1-i) +: 2]);
         end
      end
   endgenerate

   // Sqrt stages with matched payload shift register; whole pipe holds when en is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < H; i++) begin
            st_vld[i] <= 1'b0;
            st_var[i] <= '0;
            st_r[i]   <= '0;
            st_q[i]   <= '0;
            st_pay[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < H; i++) begin
            st_vld[i] <= pv_vld[i];
            st_var[i] <= pv_var[i];
            st_r[i]   <= nx_r[i];
            st_q[i]   <= nx_q[i];
            st_pay[i] <= pv_pay[i];
         end
      end
   end

   assign out_cn      = st_pay[H-1][O_CN +: IDX_W];
   assign unused_tail = ^{st_var[H-1], st_r[H-1]};

   // Clamp each root into [std_min, std_max]; inactive clusters read as zero
   always_comb begin
      out_std = '0;
      for (int k = 0; k < K; k++) begin
         if (IDX_W'(k) < out_cn)
            out_std[k*STD_W +: STD_W] = clamp_std(st_q[H-1][k*H +: H], std_min, std_max);
      end
   end

   // Output register stage; holds while downstream stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_valid        <= 1'b0;
         src_std          <= '0;
         src_w            <= '0;
         src_mean         <= '0;
         src_clusters_num <= '0;
         src_is_fg        <= 1'b0;
         src_side         <= '0;
      end else if (en) begin
         src_valid        <= st_vld[H-1];
         src_std          <= out_std;
         src_w            <= st_pay[H-1][O_W +: K*W_W];
         src_mean         <= st_pay[H-1][O_M +: K*MW];
         src_clusters_num <= out_cn;
         src_is_fg        <= st_pay[H-1][O_FG];
         src_side         <= st_pay[H-1][O_SD +: SIDE_W];
      end
   end

   assign fire = src_valid & src_ready & src_is_fg;

   // Saturating count of delivered foreground beats; a clear still counts a coincident beat
   always_ff @(posedge clk) begin
      if (!rst_n)
         fg_cnt <= '0;
      else if (clr_cnt)
         fg_cnt <= fire ? CNT_W'(1) : '0;
      else if (fire && (fg_cnt != {CNT_W{1'b1}}))
         fg_cnt <= fg_cnt + CNT_W'(1);
   end

endmodule
